// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI mode-0 master transfer sequencer.
// Shifts one W_DATA-bit word out on MOSI (MSB first) while capturing MISO,
// framed by chip-select setup/hold windows, and reports completion with a
// one-cycle done pulse and a valid flag on the received word.
// Optional build macro SPI_XFER_IRQ_EN adds a sticky completion interrupt;
// without it irq is tied low.
module spi_xfer_ctrl #(
  parameter int W_DATA   = 32,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [W_DATA-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [W_DATA-1:0] rx_data,
  output logic              rx_valid,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              irq
);

  localparam int BIT_W = (W_DATA > 1) ? $clog2(W_DATA) : 1;
  localparam int CNT_W = $clog2(CLK_DIV + CS_SETUP + 1);

  localparam logic [BIT_W-1:0] BIT_INIT  = BIT_W'(W_DATA - 1);
  // SETUP is entered on the acceptance edge and chip-select drops one edge
  // later, so the counter spans CS_SETUP+1 cycles to give CS_SETUP cycles of
  // cs_n low ahead of the first rising SPI clock edge.
  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] CNT_PHASE = CNT_W'(CLK_DIV - 1);
  // HOLD first completes the final low half-period of the SPI clock, then
  // keeps chip-select asserted for CS_SETUP cycles after it.
  localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(CLK_DIV + CS_SETUP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                rx_valid_q, rx_valid_d;
  logic [W_DATA-1:0]   rx_data_q, rx_data_d;
  logic [W_DATA-1:0]   tx_q, tx_d;
  logic [W_DATA-1:0]   rx_q, rx_d;
  logic [W_DATA-1:0]   tx_shift;
  logic [W_DATA-1:0]   rx_shift;

  assign tx_shift = tx_q << 1;
  assign rx_shift = (rx_q << 1) | W_DATA'(spi_miso);

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    tx_d       = tx_q;
    rx_d       = rx_q;

    case (state_q)
      IDLE: begin
        // abort is meaningless here, so a coincident start always wins
        if (start) begin
          state_d    = SETUP;
          cnt_d      = CNT_SETUP;
          bit_d      = BIT_INIT;
          tx_d       = tx_data;
          rx_valid_d = 1'b0;
        end
      end

      SETUP: begin
        busy_d = 1'b1;
        cs_n_d = 1'b0;
        mosi_d = tx_q[W_DATA-1];
        if (cnt_q == '0) begin
          state_d = SCK_HI;
          sclk_d  = 1'b1;
          cnt_d   = CNT_PHASE;
          rx_d    = rx_shift;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      SCK_HI: begin
        if (cnt_q == '0) begin
          sclk_d = 1'b0;
          if (bit_q != '0) begin
            state_d = SCK_LO;
            cnt_d   = CNT_PHASE;
            tx_d    = tx_shift;
            mosi_d  = tx_shift[W_DATA-1];
            bit_d   = bit_q - BIT_ONE;
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_HOLD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      SCK_LO: begin
        if (cnt_q == '0) begin
          state_d = SCK_HI;
          sclk_d  = 1'b1;
          cnt_d   = CNT_PHASE;
          rx_d    = rx_shift;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          cs_n_d     = 1'b1;
          busy_d     = 1'b0;
          mosi_d     = 1'b0;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the transfer from any active state, discarding the word.
    if ((state_q != IDLE) && abort) begin
      state_d    = IDLE;
      cs_n_d     = 1'b1;
      sclk_d     = 1'b0;
      busy_d     = 1'b0;
      mosi_d     = 1'b0;
      done_d     = 1'b0;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
    end
  end

  // Control and output registers, returned to idle by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Shift registers carry data only and are always reloaded before use.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

`ifdef SPI_XFER_IRQ_EN
  logic irq_q, irq_d;

  // Sticky interrupt: set with done, cleared on the edge after acceptance
  // (first SETUP cycle, before busy rises); set takes priority.
  always_comb begin
    irq_d = irq_q;
    if ((state_q == SETUP) && !busy_q) begin
      irq_d = 1'b0;
    end
    if (done_d) begin
      irq_d = 1'b1;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a mode-0 slave model and a
// scoreboard of expected transfers checked at each done pulse.
module tb_spi_xfer_ctrl;

  localparam int W   = 32;
  localparam int DIV = 2;
  localparam int CSS = 2;
  localparam int LAT = 1 + 2 * CSS + 2 * DIV * W;

`ifdef SPI_XFER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] tx_data;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         spi_clk;
  logic         spi_cs_n;
  logic         spi_mosi;
  logic         spi_miso;
  logic         irq;

  spi_xfer_ctrl #(
    .W_DATA  (W),
    .CLK_DIV (DIV),
    .CS_SETUP(CSS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .spi_clk (spi_clk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .irq     (irq)
  );

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           done_cnt = 0;
  int           rise_cnt = 0;
  logic [W-1:0] mosi_cap = '0;
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] sl_sh = '0;
  logic         prev_cs = 1'b1;
  logic         prev_clk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard check on done, then slave model and MOSI capture.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done === 1'b1) begin
      done_cnt++;
      check("sb_has_entry", W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("mosi_word", mosi_cap, e.tx);
        check("rx_data", rx_data, e.rx);
        check("rx_valid_done", W'(rx_valid), W'(1));
        check("sclk_rises", W'(rise_cnt), W'(W));
        check("latency", W'(cyc - e.acc), W'(LAT));
        check("irq_on_done", W'(irq), W'(IRQ_ON));
      end
    end
    if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
      sl_sh    = slave_word;
      spi_miso = sl_sh[W-1];
      mosi_cap = '0;
      rise_cnt = 0;
    end else if (spi_cs_n === 1'b0 && prev_clk === 1'b0 && spi_clk === 1'b1) begin
      mosi_cap = {mosi_cap[W-2:0], spi_mosi};
      rise_cnt++;
    end else if (spi_cs_n === 1'b0 && prev_clk === 1'b1 && spi_clk === 1'b0) begin
      sl_sh    = sl_sh << 1;
      spi_miso = sl_sh[W-1];
    end
    prev_cs  = spi_cs_n;
    prev_clk = spi_clk;
  end

  task automatic do_start(input logic [W-1:0] w, input logic [W-1:0] sw, input bit push);
    exp_t e;
    start      = 1'b1;
    tx_data    = w;
    slave_word = sw;
    if (push) begin
      e.tx  = w;
      e.rx  = sw;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("done_seen", W'(done), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    tx_data  = '0;
    spi_miso = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", W'(spi_cs_n), W'(1));
    check("rst_sclk", W'(spi_clk), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_rx_valid", W'(rx_valid), W'(0));
    check("rst_rx_data", rx_data, '0);
    check("rst_mosi", W'(spi_mosi), W'(0));
    check("rst_irq", W'(irq), W'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // full transfer with a start while busy
    do_start(32'hA5A50F0F, 32'h3CC3F00F, 1'b1);
    @(negedge clk);
    check("go_busy", W'(busy), W'(1));
    check("go_cs_n", W'(spi_cs_n), W'(0));
    check("go_mosi_msb", W'(spi_mosi), W'(1));
    check("go_sclk", W'(spi_clk), W'(0));
    repeat (18) @(negedge clk);
    check("mid_busy", W'(busy), W'(1));
    do_start(32'hFFFFFFFF, 32'h0, 1'b0);
    wait_done(300);
    repeat (10) @(negedge clk);
    check("single_done", W'(done_cnt), W'(1));
    check("idle_rx_valid", W'(rx_valid), W'(1));
    check("idle_busy", W'(busy), W'(0));
    check("idle_irq", W'(irq), W'(IRQ_ON));

    // abort after 10 bits
    do_start(32'h12345678, 32'hDEADBEEF, 1'b0);
    check("acc_irq_held", W'(irq), W'(IRQ_ON));
    @(negedge clk);
    check("acc_irq_clr", W'(irq), W'(0));
    check("acc_rx_valid", W'(rx_valid), W'(0));
    for (int i = 0; i < 200; i++) begin
      if (rise_cnt >= 10) break;
      @(negedge clk);
    end
    check("abort_reach10", W'(rise_cnt >= 10), W'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs_n", W'(spi_cs_n), W'(1));
    check("abort_sclk", W'(spi_clk), W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_rx_valid", W'(rx_valid), W'(0));
    check("abort_rx_data", rx_data, 32'h3CC3F00F);
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    check("abort_no_done", W'(done_cnt), W'(d0));

    // transfer then back-to-back start in the done cycle
    do_start(32'h0F1E2D3C, 32'h5A5AC3C3, 1'b1);
    wait_done(300);
    do_start(32'h00000001, 32'h80000001, 1'b1);
    check("b2b_rx_valid", W'(rx_valid), W'(0));
    check("b2b_rx_keep", rx_data, 32'h5A5AC3C3);
    check("b2b_irq_held", W'(irq), W'(IRQ_ON));
    @(negedge clk);
    check("b2b_busy", W'(busy), W'(1));
    check("b2b_irq_clr", W'(irq), W'(0));
    wait_done(300);
    repeat (5) @(negedge clk);
    check("b2b_rx_final", rx_data, 32'h80000001);

    // reset mid-transfer
    do_start(32'hCAFEF00D, 32'h13579BDF, 1'b0);
    repeat (30) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_cs_n", W'(spi_cs_n), W'(1));
    check("mrst_sclk", W'(spi_clk), W'(0));
    check("mrst_busy", W'(busy), W'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("mrst_rx_valid", W'(rx_valid), W'(0));
    check("mrst_rx_data", rx_data, '0);
    check("mrst_irq", W'(irq), W'(0));
    repeat (150) @(negedge clk);
    check("mrst_no_done", W'(done_cnt), W'(d0));
    check("sb_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
SPI master transfer sequencer sitting between the SPI coprocessor register file and the external SPI pins. It accepts a W_DATA-bit word plus a start strobe from the register file and drives chip-select, SPI clock and MOSI, MSB first, in mode 0 (CPOL=0, CPHA=0). It samples MISO and returns the received word with a valid flag and a one-cycle done pulse. It replaces the free-running MISO toggling with a real, handshaked transaction engine.

Parameters:
W_DATA, 32, transfer word width in bits (matches `W_CPU)
CLK_DIV, 4, clk cycles per SPI clock half-period; legal range is 1 or more
CS_SETUP, 2, clk cycles of cs_n low before the first edge, and again after the last edge; legal range is 1 or more

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-low reset; sampled on posedge clk
start  input  1  request a transfer; accepted only in IDLE
abort  input  1  terminate the current transfer immediately
tx_data  input  W_DATA  word to transmit; sampled in the cycle start is accepted
busy  output  1  high from the cycle after acceptance until return to IDLE
done  output  1  one-cycle pulse when a transfer completes normally
rx_data  output  W_DATA  last received word
rx_valid  output  1  rx_data holds a complete word
spi_clk  output  1  SPI clock; idles low
spi_cs_n  output  1  chip select, active low; idles high
spi_mosi  output  1  serial data out
spi_miso  input  1  serial data in
irq  output  1  see Optional Feature

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; busy=0, done=0, rx_data=0, rx_valid=0, spi_clk=0, spi_cs_n=1, spi_mosi=0, irq=0. Reset overrides everything, including a transfer in progress: pins return to idle on the next edge and no done pulse is produced.
- State machine states: IDLE, SETUP, SCK_LO, SCK_HI, HOLD.
- IDLE, with start=1 at edge 0:
  - latch tx_data into the tx shift register; clear rx_valid.
  - At edge 1: busy=1, spi_cs_n=0, spi_mosi=tx_data[W_DATA-1]; go to SETUP.
  - If start and abort are both high in IDLE, the start is accepted and the abort is ignored.
- SETUP: hold for CS_SETUP cycles with spi_clk=0, then go to SCK_HI.
- SCK_HI:
  - spi_clk=1 for CLK_DIV cycles.
  - On the entry edge, sample spi_miso into the LSB of the rx shift register (shift left).
  - When the phase ends, if the bit counter is nonzero, go to SCK_LO. Otherwise go to HOLD with spi_clk=0.
- SCK_LO:
  - spi_clk=0 for CLK_DIV cycles.
  - On the entry edge, shift the tx register left so spi_mosi presents the next bit; decrement the bit counter (initialised to W_DATA-1).
  - When the phase ends, go to SCK_HI.
- HOLD: spi_clk=0 and spi_cs_n=0 for CS_SETUP cycles. On exit, in a single edge:
  - spi_cs_n=1, busy=0;
  - rx_data=rx shift register, rx_valid=1;
  - done=1 for exactly one cycle; state=IDLE.
- Latency: from start edge to done-high edge is 1 + CS_SETUP + 2*CLK_DIV*W_DATA - CLK_DIV + CLK_DIV + CS_SETUP cycles, which equals 1 + 2*CS_SETUP + 2*CLK_DIV*W_DATA. There are exactly W_DATA rising edges on spi_clk.
- start while busy: ignored; tx_data is not re-latched.
- A new start is allowed in the cycle done is high (state is IDLE). That start clears rx_valid one edge later; rx_data is retained until the next completion.
- abort while busy: at the next edge go to IDLE with spi_cs_n=1, spi_clk=0, busy=0. No done pulse; rx_valid stays 0; rx_data is unchanged.
- Bit counter width is clog2(W_DATA); there is no wrap beyond W_DATA bits.

Optional Feature:
SPI_XFER_IRQ_EN
- Defined: irq is a sticky flag, set on the same edge as done. It is cleared on the edge after start is accepted. If set and clear coincide, set wins.
- Undefined: irq is tied to 0 and no flag register is synthesised.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-transfer -> spi_cs_n=1, spi_clk=0, busy=0, rx_valid=0, rx_data=0; no done pulse.
- Full transfer (CLK_DIV=2, CS_SETUP=2, W_DATA=32): tx_data=32'hA5A50F0F, slave model drives 32'h3CC3F00F on MISO -> MOSI captured at spi_clk rising edges equals 32'hA5A50F0F; exactly 32 spi_clk rising edges; done at edge 133 after start; rx_data=32'h3CC3F00F; rx_valid=1.
- Start while busy: second start with tx_data=32'hFFFFFFFF at cycle 20 -> ignored; MOSI still shifts 32'hA5A50F0F; a single done pulse.
- Abort after 10 bits -> spi_cs_n high at the next edge, busy=0, no done, rx_data keeps its previous value (32'h3CC3F00F), rx_valid=0.
- Back-to-back: start asserted in the done cycle with tx_data=32'h00000001 -> second transfer begins; rx_valid drops 1 edge later; the second done arrives 133 cycles later.
- SPI_XFER_IRQ_EN defined: irq rises with done, stays high through idle cycles, and clears one edge after the next start; with the macro undefined, irq stays 0 throughout.
